// File: rtl/ring_meter_pkg.sv
// Shared constants for the ring-oscillator frequency meter.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ring_meter_pkg;

   // Measurement FSM encoding
   localparam logic [0:0] ST_SETTLE = 1'b0;
   localparam logic [0:0] ST_GATE   = 1'b1;

   // Cycles spent settling after reset or a ring re-selection
   localparam int SETTLE_LEN = 8;
   localparam int SETTLE_W   = 3;
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = 3'(SETTLE_LEN - 1);

   // Flop count of the asynchronous input synchroniser
   localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/sync2.sv
// Single-bit multi-flop synchroniser for asynchronous input pins, reset to 0.
// Latency: SYNC_DEPTH clocks from input sample to output.
// Backpressure: none; free-running every clock.
module sync2 import ring_meter_pkg::*; (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic [SYNC_DEPTH-1:0] stage_q;
   logic [SYNC_DEPTH-1:0] stage_d;

   // shift the raw input one stage deeper each clock
   always_comb begin
      stage_d = {stage_q[SYNC_DEPTH-2:0], i_d};
   end

   // synchroniser chain, cleared on reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign o_q = stage_q[SYNC_DEPTH-1];

endmodule

// File: rtl/ring_meter.sv
// Counts rising edges of the selected ring over a 2^pGATE_LOG2-clock gate and publishes the count.
// Latency: ring edge counted 3 clocks after first sample; o_valid the cycle after the terminal gate cycle.
// Backpressure: none; results are overwritten each window, a selection change restarts measurement.
module ring_meter import ring_meter_pkg::*; #(
   parameter int pGATE_LOG2 = 12,
   parameter int pCNT_W     = 16,
   parameter int pGRAY      = 1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [5:0] i_sel,
   input  logic       i_ring,
   input  logic       i_hi,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_busy
);

   localparam logic [pCNT_W-1:0]     CNT_MAX  = {pCNT_W{1'b1}};
   localparam logic [pGATE_LOG2-1:0] GATE_MAX = {pGATE_LOG2{1'b1}};

   logic                  ring_s;
   logic                  edge_q,   edge_d;
   logic                  rise;
   logic [5:0]            sel_q,    sel_d;
   logic                  sel_chg;
   logic [0:0]            state_q,  state_d;
   logic [SETTLE_W-1:0]   settle_q, settle_d;
   logic [pGATE_LOG2-1:0] gate_q,   gate_d;
   logic [pCNT_W-1:0]     cnt_q,    cnt_d;
   logic [15:0]           result_q, result_d;
   logic                  valid_q,  valid_d;
   logic [pCNT_W-1:0]     cnt_inc;
   logic [15:0]           cnt_ext;
   logic [15:0]           result_enc;

   sync2 u_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_ring),
      .o_q   (ring_s)
   );

   // edge detect on the synchronised ring, plus selection change detect
   always_comb begin
      edge_d  = ring_s;
      rise    = ring_s & ~edge_q;
      sel_d   = i_sel;
      sel_chg = (i_sel != sel_q);
   end

   // saturating count including this cycle's edge, widened and optionally Gray-coded
   always_comb begin
      if (cnt_q == CNT_MAX) begin
         cnt_inc = cnt_q;
      end else begin
         cnt_inc = cnt_q + pCNT_W'(rise);
      end
      cnt_ext = 16'(cnt_inc);
      if (pGRAY != 0) begin
         result_enc = cnt_ext ^ (cnt_ext >> 1);
      end else begin
         result_enc = cnt_ext;
      end
   end

   // settle / gate sequencing; a selection change overrides everything,
   // including a coincident terminal count, so an aborted window never publishes
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      gate_d   = gate_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      valid_d  = 1'b0;
      if (sel_chg) begin
         state_d  = ST_SETTLE;
         settle_d = '0;
         gate_d   = '0;
         cnt_d    = '0;
      end else if (state_q == ST_SETTLE) begin
         gate_d = '0;
         cnt_d  = '0;
         if (settle_q == SETTLE_LAST) begin
            state_d  = ST_GATE;
            settle_d = '0;
         end else begin
            settle_d = settle_q + SETTLE_W'(1);
         end
      end else begin
         if (gate_q == GATE_MAX) begin
            // terminal cycle: publish and start the next window back-to-back
            result_d = result_enc;
            valid_d  = 1'b1;
            cnt_d    = '0;
            gate_d   = '0;
         end else begin
            cnt_d  = cnt_inc;
            gate_d = gate_q + pGATE_LOG2'(1);
         end
      end
   end

   // state registers; sel_q loads the live selection during reset so that
   // the first measurement after reset is not restarted by a stale copy
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         edge_q   <= 1'b0;
         sel_q    <= i_sel;
         state_q  <= ST_SETTLE;
         settle_q <= '0;
         gate_q   <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         edge_q   <= edge_d;
         sel_q    <= sel_d;
         state_q  <= state_d;
         settle_q <= settle_d;
         gate_q   <= gate_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   assign o_data  = i_hi ? result_q[15:8] : result_q[7:0];
   assign o_valid = valid_q;
   assign o_busy  = (state_q == ST_SETTLE);

endmodule

// File: tb/tb_ring_meter.sv
// Bench for ring_meter: three parameterisations share one stimulus stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_ring_meter;

   localparam int GATE_LEN   = 64;
   localparam int SETTLE_CYC = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       ring;
   logic       hi;
   logic [5:0] sel;
   logic [7:0] data [3];
   logic       vld  [3];
   logic       busy [3];

   always #5 clk = ~clk;

   // 0: binary, 1: Gray, 2: 4-bit counter binary (saturation)
   ring_meter #(.pGATE_LOG2(6), .pCNT_W(16), .pGRAY(0)) u_bin (
      .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_ring(ring), .i_hi(hi),
      .o_data(data[0]), .o_valid(vld[0]), .o_busy(busy[0]));
   ring_meter #(.pGATE_LOG2(6), .pCNT_W(16), .pGRAY(1)) u_gray (
      .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_ring(ring), .i_hi(hi),
      .o_data(data[1]), .o_valid(vld[1]), .o_busy(busy[1]));
   ring_meter #(.pGATE_LOG2(6), .pCNT_W(4), .pGRAY(0)) u_sat (
      .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_ring(ring), .i_hi(hi),
      .o_data(data[2]), .o_valid(vld[2]), .o_busy(busy[2]));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Timeline view: a restart (reset or selection change) opens 8 settle
   // cycles; after that every 64-cycle window sums the rises of the sampled
   // ring, each rise landing 2 edges after it was sampled.
   int          m_ph = 0;
   bit          m_live = 1'b0;
   bit          m_h1 = 1'b0, m_h2 = 1'b0, m_h3 = 1'b0;
   logic [5:0]  m_sel_prev = '0;
   int          m_acc [3] = '{0, 0, 0};
   logic [15:0] m_res [3] = '{16'h0, 16'h0, 16'h0};
   bit          m_vld = 1'b0;
   int          m_max [3] = '{65535, 65535, 15};
   bit          m_gray[3] = '{1'b0, 1'b1, 1'b0};

   function automatic logic [15:0] encode(input int v, input bit g);
      logic [15:0] b;
      b = v[15:0];
      return g ? (b ^ (b >> 1)) : b;
   endfunction

   always @(posedge clk) begin : model
      bit rise_m;
      bit smp;
      bit restart;
      smp     = rst ? 1'b0 : ring;
      rise_m  = m_h2 & ~m_h3;
      restart = rst || (sel != m_sel_prev);
      m_sel_prev = sel;
      if (rst) begin
         m_h1 = 1'b0; m_h2 = 1'b0; m_h3 = 1'b0;
         m_live = 1'b1;
      end else begin
         m_h3 = m_h2; m_h2 = m_h1; m_h1 = smp;
      end
      m_vld = 1'b0;
      if (restart) begin
         m_ph = 0;
         for (int d = 0; d < 3; d++) begin
            m_acc[d] = 0;
            if (rst) m_res[d] = 16'h0;
         end
      end else begin
         m_ph++;
         if (m_ph > SETTLE_CYC) begin
            for (int d = 0; d < 3; d++)
               m_acc[d] = (m_acc[d] + int'(rise_m) > m_max[d]) ? m_max[d] : m_acc[d] + int'(rise_m);
            if ((m_ph - SETTLE_CYC) % GATE_LEN == 0) begin
               for (int d = 0; d < 3; d++) begin
                  m_res[d] = encode(m_acc[d], m_gray[d]);
                  m_acc[d] = 0;
               end
               m_vld = 1'b1;
            end
         end
      end
   end

   // continuous comparison of every output against the model
   always @(negedge clk) begin : scoreboard
      #2;
      if (m_live) begin
         for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("o_valid[%0d]", d), 32'(vld[d]), 32'(m_vld));
            check_eq($sformatf("o_busy[%0d]", d), 32'(busy[d]), 32'(m_ph < SETTLE_CYC));
            check_eq($sformatf("o_data[%0d]", d), 32'(data[d]),
                     32'(hi ? m_res[d][15:8] : m_res[d][7:0]));
         end
      end
   end

   // ---------------- stimulus ----------------
   int ring_per = 4;   // >=2 periodic, 0 random, <0 held by caller
   int ring_ph  = 0;

   task automatic drive_ring();
      if (ring_per == 0) begin
         ring = 1'($urandom_range(0, 1));
      end else if (ring_per > 0) begin
         ring_ph = (ring_ph + 1) % ring_per;
         ring    = (ring_ph < ring_per / 2);
      end
   endtask

   task automatic to_neg();
      @(negedge clk);
      drive_ring();
   endtask

   task automatic to_pos();
      @(posedge clk);
      #3;
   endtask

   // call from the negedge phase; counts edges until o_valid is seen
   task automatic wait_vld(input string tag, output int n);
      n = 0;
      forever begin
         to_pos();
         n++;
         if (vld[0] === 1'b1 || n >= 400) break;
         to_neg();
      end
      if (vld[0] !== 1'b1) check_eq({tag, "_timeout"}, 32'(vld[0]), 32'd1);
   endtask

   initial begin
      int lat;
      int driven;
      int sum;
      int nv;
      bit prev;
      rst = 1'b1; sel = 6'h01; ring = 1'b0; hi = 1'b0;
      repeat (3) to_neg();
      rst = 1'b0;

      // first window after reset, ring period 4
      wait_vld("rst_lat", lat);
      check_eq("first_vld_lat", lat, 32'd72);
      check_eq("bin_p4", data[0], 32'h10);
      check_eq("gray_p4", data[1], 32'h18);
      check_eq("sat_p4", data[2], 32'h0F);
      hi = 1'b1; #1;
      check_eq("bin_p4_hi", data[0], 32'h00);
      hi = 1'b0; #1;

      // ring period 8
      ring_per = 8;
      to_neg(); wait_vld("p8a", lat);
      to_neg(); wait_vld("p8b", lat);
      check_eq("period_between_vld", lat, 32'd64);
      check_eq("bin_p8", data[0], 32'h08);
      check_eq("gray_p8", data[1], 32'h0C);

      // selection change at window cycle 30
      repeat (30) begin to_neg(); to_pos(); end
      to_neg(); sel = 6'h02;
      wait_vld("sel30", lat);
      check_eq("sel30_lat", lat, 32'd73);
      check_eq("sel30_res", data[0], 32'h08);

      // selection change on the terminal cycle
      repeat (63) begin to_neg(); to_pos(); end
      to_neg(); sel = 6'h04;
      wait_vld("selterm", lat);
      check_eq("selterm_lat", lat, 32'd73);

      // one-cycle reset at window cycle 40
      repeat (40) begin to_neg(); to_pos(); end
      to_neg(); rst = 1'b1;
      to_neg(); rst = 1'b0;
      #2;
      check_eq("rst_data", data[0], 32'h00);
      check_eq("rst_vld", vld[0], 32'd0);
      check_eq("rst_busy", busy[0], 32'd1);
      wait_vld("rst40", lat);
      check_eq("rst40_lat", lat, 32'd72);
      check_eq("rst40_res", data[0], 32'h08);

      // boundary: rise lands on every terminal cycle, four windows
      to_neg(); ring_per = -1; ring = 1'b0;
      repeat (3) begin to_pos(); to_neg(); end
      wait_vld("bnd_start", lat);
      driven = 0; sum = 0; nv = 0; prev = 1'b0;
      for (int i = 1; i <= 4 * GATE_LEN; i++) begin
         to_neg();
         ring = ((i % 8) >= 6);
         if (ring && !prev) driven++;
         prev = ring;
         to_pos();
         if (vld[0] === 1'b1) begin
            nv++;
            check_eq("bnd_win", data[0], 32'd8);
            sum += int'(data[0]);
         end
      end
      check_eq("bnd_windows", nv, 32'd4);
      check_eq("bnd_total", sum, driven);

      // randomized traffic: ring shape, byte select, selection changes, resets
      for (int seg = 0; seg < 6; seg++) begin
         ring_per = $urandom_range(0, 9);
         if (ring_per == 1) ring_per = 2;
         repeat (400) begin
            to_neg();
            hi  = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 249) == 0) sel = 6'(1 << $urandom_range(0, 5));
         end
      end
      to_neg(); rst = 1'b0;
      repeat (4) to_neg();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
